// File: rtl/seg_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment scanner.
// Pure definitions, no logic and no flow control.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [7:0] seg_t;

  // Bit order {a,b,c,d,e,f,g,dp}; dp is always 0 here and is merged in later.
  localparam seg_t HEX_SEG [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to segment pattern lookup; combinational, zero latency.
// No handshake: the output follows the input within the same cycle.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seven_seg_scanner.sv
// Eight-digit multiplexed display driver with frame-aligned double-buffered updates.
// Outputs registered, one cycle after each step; load is always accepted (latest wins).
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic [7:0]  blank,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_tick,
  output logic [7:0]  enable,
  output seg_t        seg
);

  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  generate
    if (DIV < 2) begin : g_div_check
      $error("seven_seg_scanner: DIV must be at least 2");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          pending_q, pending_d;
  logic [31:0]   stg_data_q, stg_data_d;
  logic [7:0]    stg_dp_q, stg_dp_d;
  logic [7:0]    stg_blank_q, stg_blank_d;
  logic [31:0]   dsp_data_q, dsp_data_d;
  logic [7:0]    dsp_dp_q, dsp_dp_d;
  logic [7:0]    dsp_blank_q, dsp_blank_d;
  logic [7:0]    enable_q, enable_d;
  seg_t          seg_q, seg_d;
  logic          load_ack_q, load_ack_d;
  logic          frame_tick_q, frame_tick_d;

  logic          step;
  logic          wrap;
  logic          xfer;
  logic [3:0]    cur_nib;
  seg_t          cur_hex;

  hex_to_seg u_hex_to_seg (
    .nib (cur_nib),
    .seg (cur_hex)
  );

  always_comb begin
    step = (cnt_q == CW'(DIV - 1));
    wrap = step && (idx_q == IW'(NUM_DIGITS - 1));
    xfer = wrap && pending_q;

    cnt_d = step ? '0 : cnt_q + 1'b1;
    idx_d = step ? idx_q + 1'b1 : idx_q;

    // A transfer always takes the old staging; a coincident load refills it.
    dsp_data_d  = xfer ? stg_data_q  : dsp_data_q;
    dsp_dp_d    = xfer ? stg_dp_q    : dsp_dp_q;
    dsp_blank_d = xfer ? stg_blank_q : dsp_blank_q;
    stg_data_d  = load ? data  : stg_data_q;
    stg_dp_d    = load ? dp    : stg_dp_q;
    stg_blank_d = load ? blank : stg_blank_q;
    pending_d   = load | (pending_q & ~xfer);

    // Output registers look at next-state idx/display so they land one cycle after the step.
    cur_nib  = dsp_data_d[{idx_d, 2'b00} +: 4];
    enable_d = '0;
    seg_d    = '0;
    if (!dsp_blank_d[idx_d]) begin
      enable_d = 8'b1 << idx_d;
      seg_d    = cur_hex | {7'b0, dsp_dp_d[idx_d]};
    end

    frame_tick_d = wrap;
    load_ack_d   = xfer;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      stg_data_q   <= '0;
      stg_dp_q     <= '0;
      stg_blank_q  <= 8'hFF;
      dsp_data_q   <= '0;
      dsp_dp_q     <= '0;
      dsp_blank_q  <= 8'hFF;
      enable_q     <= '0;
      seg_q        <= '0;
      load_ack_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      stg_data_q   <= stg_data_d;
      stg_dp_q     <= stg_dp_d;
      stg_blank_q  <= stg_blank_d;
      dsp_data_q   <= dsp_data_d;
      dsp_dp_q     <= dsp_dp_d;
      dsp_blank_q  <= dsp_blank_d;
      enable_q     <= enable_d;
      seg_q        <= seg_d;
      load_ack_q   <= load_ack_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign enable     = enable_q;
  assign seg        = seg_q;
  assign load_ack   = load_ack_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner against a frame-level behavioural model.
// DIV=4: digit shown = (edges since reset / 4) mod 8, frames every 32 edges.
module tb_seven_seg_scanner;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic [7:0]  dp;
  logic [7:0]  blank;
  logic        load;
  logic        load_ack;
  logic        frame_tick;
  logic [7:0]  enable;
  logic [7:0]  seg;

  seven_seg_scanner #(.DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .dp         (dp),
    .blank      (blank),
    .load       (load),
    .load_ack   (load_ack),
    .frame_tick (frame_tick),
    .enable     (enable),
    .seg        (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int acks   = 0;

  // Model state: edges since reset release, staging and shown content as plain values.
  int          k;
  logic [31:0] m_sd, m_dd;
  logic [7:0]  m_sp, m_dp, m_sb, m_db;
  bit          m_pend;
  logic [7:0]  hex_tab [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %h expected %h", tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    k      = 0;
    m_sd   = '0;
    m_dd   = '0;
    m_sp   = '0;
    m_dp   = '0;
    m_sb   = 8'hFF;
    m_db   = 8'hFF;
    m_pend = 1'b0;
  endtask

  task automatic cycle(input bit ld, input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
    logic [7:0] e_en, e_seg;
    logic [3:0] nib;
    bit         e_tick, e_ack;
    int         dig;
    load  = ld;
    data  = d;
    dp    = p;
    blank = b;
    @(posedge clk);
    k++;
    e_tick = (k % FRAME == 0);
    e_ack  = 1'b0;
    if (e_tick && m_pend) begin
      m_dd   = m_sd;
      m_dp   = m_sp;
      m_db   = m_sb;
      m_pend = 1'b0;
      e_ack  = 1'b1;
    end
    if (ld) begin
      m_sd   = d;
      m_sp   = p;
      m_sb   = b;
      m_pend = 1'b1;
    end
    dig = (k / DIV) % 8;
    nib = 4'((m_dd >> (4 * dig)) & 32'hF);
    if (m_db[dig]) begin
      e_en  = 8'h00;
      e_seg = 8'h00;
    end else begin
      e_en  = 8'h01 << dig;
      e_seg = hex_tab[nib] | {7'b0, m_dp[dig]};
    end
    #1;
    check("enable", {24'b0, enable}, {24'b0, e_en});
    check("seg", {24'b0, seg}, {24'b0, e_seg});
    check("frame_tick", {31'b0, frame_tick}, {31'b0, e_tick});
    check("load_ack", {31'b0, load_ack}, {31'b0, e_ack});
    if (load_ack) acks++;
    load  = 1'b0;
    data  = $urandom;
    dp    = 8'($urandom);
    blank = 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 8'($urandom), 8'($urandom));
  endtask

  task automatic align(input int phase);
    for (int i = 0; i < FRAME && (k % FRAME) != phase; i++) idle(1);
  endtask

  initial begin
    int a0;
    hex_tab = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    rst_n = 1'b0;
    load  = 1'b0;
    data  = '0;
    dp    = '0;
    blank = '0;
    model_reset();
    #27;
    check("rst_enable", {24'b0, enable}, 32'h0);
    check("rst_seg", {24'b0, seg}, 32'h0);
    check("rst_tick", {31'b0, frame_tick}, 32'h0);
    check("rst_ack", {31'b0, load_ack}, 32'h0);
    rst_n = 1'b1;

    // Dark for three frames with ticks only.
    idle(3 * FRAME);

    cycle(1'b1, 32'h76543210, 8'h00, 8'h00);
    idle(2 * FRAME);
    cycle(1'b1, 32'hFEDCBA98, 8'h01, 8'h80);
    idle(2 * FRAME);

    // Two loads in one frame: only the second shows, one ack.
    align(2);
    a0 = acks;
    cycle(1'b1, $urandom, 8'($urandom), 8'h00);
    idle(5);
    cycle(1'b1, $urandom, 8'($urandom), 8'h00);
    idle(FRAME);
    check("two_load_acks", acks - a0, 1);

    // Load on the boundary cycle while pending.
    align(5);
    a0 = acks;
    cycle(1'b1, $urandom, 8'($urandom), 8'h00);
    align(FRAME - 1);
    cycle(1'b1, $urandom, 8'($urandom), 8'h00);
    idle(FRAME + 2);
    check("boundary_load_acks", acks - a0, 2);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19, 0) == 0)
        cycle(1'b1, $urandom, 8'($urandom), 8'($urandom_range(1, 0) == 0 ? 0 : $urandom));
      else
        idle(1);
    end

    // Asynchronous reset in the middle of digit 5.
    align(0);
    cycle(1'b1, $urandom, 8'($urandom), 8'h00);
    idle(FRAME);
    align(5 * DIV + 2);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_enable", {24'b0, enable}, 32'h0);
    check("midrst_seg", {24'b0, seg}, 32'h0);
    check("midrst_tick", {31'b0, frame_tick}, 32'h0);
    check("midrst_ack", {31'b0, load_ack}, 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(FRAME + 8);
    cycle(1'b1, $urandom, 8'($urandom), 8'h00);
    idle(2 * FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
